fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of the no-pipeline core. Owns the program counter, drives the word-aligned byte address into `instruction_memory` (combinational read, 512 words, indexed by address>>2), registers the returned word with its PC, and hands it to decode over a valid/ready handshake. Handles control-flow redirects from execute, and detects misaligned or out-of-range fetches.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `IMEM_WORDS`, 512, instruction memory depth in words; valid byte range is 0 .. IMEM_WORDS*4-1

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `imem_addr` out XLEN: byte address to `instruction_memory.address`; equals current `pc`
- `imem_data` in 32: `instruction_memory.data_out`, valid in the same cycle as `imem_addr`
- `redirect_valid` in 1: taken branch/jump/trap from execute
- `redirect_pc` in XLEN: redirect target byte address
- `out_valid` out 1: fetched instruction is presented
- `out_ready` in 1: decode accepts the presented instruction this cycle
- `out_pc` out XLEN: PC of the presented instruction
- `out_instr` out 32: presented instruction word
- `out_fault` out 1: presented entry is a fetch fault; `out_instr` is NOP
- `fetch_count` out 32: number of accepted handshakes, wraps modulo 2^32

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT; BOOT always goes to RUN after one cycle with no fetch.
- Capture condition (RUN, no redirect): `out_valid==0` or (`out_valid && out_ready`). On capture: `out_pc<=pc`, `out_instr<=imem_data`, `out_fault<=0`, `out_valid<=1`, `pc<=pc+4`, truncated to XLEN bits.
- Fault check in RUN at capture: `pc[1:0]!=0` or `pc >= IMEM_WORDS*4` -> capture `out_pc<=pc`, `out_instr<=32'h0000_0013`, `out_fault<=1`, `out_valid<=1`, `pc` unchanged, go to HALT.
- HALT: no captures. The held entry stays until accepted, then `out_valid<=0`. Only a redirect leaves HALT.
- Redirect, any state except BOOT, has highest priority: `pc<=redirect_pc`, `out_valid<=0`, no capture that cycle, state<=RUN. A same-cycle `out_valid && out_ready` still counts as accepted. The flush only drops the next entry.
- No capture when `out_valid && !out_ready`. All output registers hold stable.
- `fetch_count` increments on every cycle where `out_valid && out_ready`, including fault entries.

## Timing
- Reset values: `pc=RESET_PC`, `out_valid=0`, `out_pc=0`, `out_instr=0`, `out_fault=0`, `fetch_count=0`, state BOOT. `imem_addr` is RESET_PC from the cycle after reset.
- First `out_valid=1` appears 2 cycles after `rst` deasserts: one BOOT cycle, then one capture.
- Steady state with `out_ready=1`: one instruction per cycle, PC +4 per cycle.
- Redirect penalty is exactly 1 bubble. Redirect in cycle N sets `out_valid=0` in N+1, and the target is presented in N+2.
- `rst` asserted mid-stream overrides everything, including redirects, on that edge.
- Wrap-around: `pc=2^XLEN-4` increments to 0, but that address is already out of range and faults first.

## Structure
- Shared package `riscky_pkg`: `NOP_INSTR=32'h0000_0013` and the state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2).
- One natural sub-module, `fetch_out_reg`. It holds valid/pc/instr/fault and takes load/flush/accept controls. The PC, FSM and counter stay in `fetch_unit`.

## Test plan
- Reset then `out_ready=1`, memory words 0..3 = 0xA,0xB,0xC,0xD -> `out_valid` rises 2 cycles after reset, then out_pc 0,4,8,12 with matching instrs on consecutive cycles; `fetch_count`=4.
- Backpressure: `out_ready=0` for 3 cycles while presenting pc=8 -> out_pc/out_instr hold; `imem_addr` stays 12; on release the next entry is pc=12.
- Redirect to 0x40 in cycle N while pc=8 is presented and accepted -> `out_valid=0` in N+1, out_pc=0x40 in N+2, `fetch_count` includes pc=8.
- Misaligned redirect to 0x42 -> out_fault=1, out_instr=0x00000013, out_pc=0x42, then `out_valid=0` after accept. Stays in HALT until a redirect to 0x10 resumes at out_pc=0x10.
- Sequential run to pc=0x800 (IMEM_WORDS=512) -> fault entry with out_pc=0x800 and no further fetches; `rst` pulse mid-HALT -> restart from RESET_PC, `fetch_count`=0.

Source files
------------

// File: rtl/riscky_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscky_pkg
// Description : Shared constants and types for the riscky core front end:
//               canonical NOP encoding and the fetch FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package riscky_pkg;

  // addi x0, x0, 0 -- substituted for the instruction word of a faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage : riscky_pkg
`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_reg
// Description : Output holding register of the fetch unit. Holds one
//               presented entry (valid/pc/instr/fault) for decode.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset
//   i_load   in  : capture i_pc/i_instr/i_fault and mark entry valid
//   i_flush  in  : drop the held entry (highest priority)
//   i_accept in  : decode consumed the held entry this cycle
//   i_pc, i_instr, i_fault in : entry to capture
//   o_valid, o_pc, o_instr, o_fault out : presented entry
// Revision    : 1.0  initial release
// ============================================================================
module fetch_out_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_accept,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  input  logic            i_fault,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_fault
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_fault;

  // Flush only clears valid; payload fields are don't-care while invalid.
  // A load in the same cycle as an accept replaces the consumed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_fault <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_fault <= i_fault;
    end else if (i_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_fault = r_fault;

endmodule : fetch_out_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the PC, reads the
//               combinational instruction memory, presents the fetched word
//               to decode over valid/ready, handles redirects from execute
//               and halts on misaligned / out-of-range fetches.
//   clk            in  : clock, rising edge
//   rst            in  : synchronous active-high reset
//   imem_addr      out : byte address to instruction memory (= pc)
//   imem_data      in  : memory word for imem_addr, same cycle
//   redirect_valid in  : taken branch/jump/trap from execute
//   redirect_pc    in  : redirect target byte address
//   out_valid      out : entry presented to decode
//   out_ready      in  : decode accepts the presented entry
//   out_pc         out : PC of presented entry
//   out_instr      out : presented instruction word (NOP on fault)
//   out_fault      out : presented entry is a fetch fault
//   fetch_count    out : accepted handshakes, wraps modulo 2^32
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import riscky_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 512
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault,
  output logic [31:0]     fetch_count
);

  // One extra bit so a memory filling the whole address space cannot overflow
  localparam logic [XLEN:0] c_imem_bytes = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(4);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [31:0]     r_fetch_count;

  logic w_accept;
  logic w_slot_free;
  logic w_fetch_fault;
  logic w_load;
  logic w_load_fault;
  logic w_flush;

  assign w_accept      = out_valid && out_ready;
  assign w_slot_free   = !out_valid || w_accept;
  assign w_fetch_fault = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= c_imem_bytes);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_load       = 1'b0;
    w_load_fault = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      // Redirects are ignored during the single boot cycle.
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_flush     = 1'b1;
        end else if (w_slot_free) begin
          w_load = 1'b1;
          if (w_fetch_fault) begin
            // PC is frozen on the faulting address until a redirect.
            w_load_fault = 1'b1;
            w_state_nxt  = HALT;
          end else begin
            w_pc_nxt = r_pc + XLEN'(4);
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  fetch_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_flush  (w_flush),
    .i_accept (w_accept),
    .i_pc     (r_pc),
    .i_instr  (w_load_fault ? NOP_INSTR : imem_data),
    .i_fault  (w_load_fault),
    .o_valid  (out_valid),
    .o_pc     (out_pc),
    .o_instr  (out_instr),
    .o_fault  (out_fault)
  );

  assign imem_addr   = r_pc;
  assign fetch_count = r_fetch_count;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               hand-written fault/halt/reset sequences and a randomized
//               phase checked against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [512];

  int n_checks = 0;
  int n_fail   = 0;

  assign imem_data = mem[imem_addr[10:2]];

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (512)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
    logic [31:0] ecnt;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy,
                              logic ev, logic [31:0] epc, logic [31:0] ei,
                              logic ef, logic [31:0] ecnt, logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = ei; v.ef = ef; v.ecnt = ecnt; v.eaddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] ei, input logic ef,
                            input logic [31:0] ecnt, input logic [31:0] ea);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".count"}, fetch_count, ecnt);
    chk({tag, ".imem_addr"}, imem_addr, ea);
    if (ev) begin
      chk({tag, ".pc"}, out_pc, epc);
      chk({tag, ".instr"}, out_instr, ei);
      chk({tag, ".fault"}, {31'd0, out_fault}, {31'd0, ef});
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model for the random phase ----------------
  logic        m_booting, m_halted, m_valid, m_fault;
  logic [31:0] m_pc, m_out_pc, m_out_instr, m_cnt;

  function automatic logic bad_addr(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd2048);
  endfunction

  task automatic model_cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic taken;
    if (r) begin
      m_booting = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
      return;
    end
    taken = m_valid && rdy;
    if (taken) m_cnt = m_cnt + 1;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (rv) begin
      m_pc = rp; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!m_halted && (!m_valid || taken)) begin
      m_valid = 1'b1; m_out_pc = m_pc;
      if (bad_addr(m_pc)) begin
        m_out_instr = NOP; m_fault = 1'b1; m_halted = 1'b1;
      end else begin
        m_out_instr = mem[m_pc / 4]; m_fault = 1'b0; m_pc = m_pc + 4;
      end
    end else if (taken) begin
      m_valid = 1'b0;
    end
  endtask

  vec_t vecs[18];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD;

    //            rst rv  rpc          rdy  ev  epc          instr          f   cnt  addr
    vecs[0]  = mk(1, 0, 32'h0,    1, 0, 32'h0,  32'h0,         0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,    1, 0, 32'h0,  32'h0,         0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,    1, 1, 32'h0,  32'hA,         0, 0, 32'h4);
    vecs[3]  = mk(0, 0, 32'h0,    1, 1, 32'h4,  32'hB,         0, 1, 32'h8);
    vecs[4]  = mk(0, 0, 32'h0,    1, 1, 32'h8,  32'hC,         0, 2, 32'hC);
    vecs[5]  = mk(0, 0, 32'h0,    0, 1, 32'h8,  32'hC,         0, 2, 32'hC);
    vecs[6]  = mk(0, 0, 32'h0,    0, 1, 32'h8,  32'hC,         0, 2, 32'hC);
    vecs[7]  = mk(0, 0, 32'h0,    0, 1, 32'h8,  32'hC,         0, 2, 32'hC);
    vecs[8]  = mk(0, 0, 32'h0,    1, 1, 32'hC,  32'hD,         0, 3, 32'h10);
    vecs[9]  = mk(0, 0, 32'h0,    1, 1, 32'h10, 32'h1000_0004, 0, 4, 32'h14);
    // redirect while the presented entry is accepted: counted, then one bubble
    vecs[10] = mk(0, 1, 32'h40,   1, 0, 32'h0,  32'h0,         0, 5, 32'h40);
    vecs[11] = mk(0, 0, 32'h0,    1, 1, 32'h40, 32'h1000_0010, 0, 5, 32'h44);
    // redirect while the presented entry is stalled: entry dropped, not counted
    vecs[12] = mk(0, 1, 32'h80,   0, 0, 32'h0,  32'h0,         0, 5, 32'h80);
    vecs[13] = mk(0, 0, 32'h0,    1, 1, 32'h80, 32'h1000_0020, 0, 5, 32'h84);
    vecs[14] = mk(0, 0, 32'h0,    1, 1, 32'h84, 32'h1000_0021, 0, 6, 32'h88);
    // reset wins over a same-cycle redirect; redirect during boot is ignored
    vecs[15] = mk(1, 1, 32'h200,  1, 0, 32'h0,  32'h0,         0, 0, 32'h0);
    vecs[16] = mk(0, 1, 32'h100,  1, 0, 32'h0,  32'h0,         0, 0, 32'h0);
    vecs[17] = mk(0, 0, 32'h0,    1, 1, 32'h0,  32'hA,         0, 0, 32'h4);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                 vecs[i].ef, vecs[i].ecnt, vecs[i].eaddr);
    end

    // ---- misaligned redirect -> fault entry, HALT, resume by redirect ----
    step(0, 1, 32'h42, 1);
    expect_out("mis.redir", 0, 0, 0, 0, 1, 32'h42);
    step(0, 0, 32'h0, 0);
    expect_out("mis.fault", 1, 32'h42, NOP, 1, 1, 32'h42);
    step(0, 0, 32'h0, 0);
    expect_out("mis.hold", 1, 32'h42, NOP, 1, 1, 32'h42);
    step(0, 0, 32'h0, 1);
    expect_out("mis.accept", 0, 0, 0, 0, 2, 32'h42);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 1);
      expect_out("mis.halt", 0, 0, 0, 0, 2, 32'h42);
    end
    step(0, 1, 32'h10, 1);
    expect_out("mis.resume0", 0, 0, 0, 0, 2, 32'h10);
    step(0, 0, 32'h0, 1);
    expect_out("mis.resume1", 1, 32'h10, 32'h1000_0004, 0, 2, 32'h14);

    // ---- sequential run off the end of memory ----
    step(0, 1, 32'h7F0, 1);
    expect_out("end.redir", 0, 0, 0, 0, 3, 32'h7F0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 32'h0, 1);
      expect_out($sformatf("end.seq%0d", k), 1, 32'h7F0 + 4*k, 32'h1000_01FC + k, 0,
                 32'd3 + k, 32'h7F4 + 4*k);
    end
    step(0, 0, 32'h0, 1);
    expect_out("end.fault", 1, 32'h800, NOP, 1, 7, 32'h800);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 1);
      expect_out("end.halt", 0, 0, 0, 0, 8, 32'h800);
    end
    // reset pulse during HALT restarts from RESET_PC with a cleared counter
    step(1, 0, 32'h0, 1);
    expect_out("end.rst", 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 1);
    expect_out("end.boot", 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 1);
    expect_out("end.first", 1, 32'h0, 32'hA, 0, 0, 32'h4);

    // ---- randomized phase against the behavioural model ----
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    m_booting = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    m_pc = 0; m_out_pc = 0; m_out_instr = 0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        r, rv, rdy;
      logic [31:0] rp;
      int          sel;
      r   = (c == 0) || ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 9);
      case (sel)
        6:       rp = {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(1, 3))};
        7:       rp = 32'h7F0 + 4 * $urandom_range(0, 3);
        8:       rp = 32'h800 + $urandom;
        9:       rp = 32'hFFFF_FFFC;
        default: rp = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
      endcase
      model_cycle(r, rv, rp, rdy);
      step(r, rv, rp, rdy);
      expect_out($sformatf("rnd%0d", c), m_valid, m_out_pc, m_out_instr, m_fault, m_cnt, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
